// File: rtl/ir_nec_rx.sv
// NEC infrared frame receiver with an Avalon-MM register slave (DATA, STATUS, CONTROL, ERRCNT).
// Latency: a frame lands in DATA 3 clk after the stop-mark falling edge reaches in_port; readdata 1 clk after read.
// Backpressure: none; an unread frame is overwritten and flagged as overrun.
// Ports: clk/reset (sync, active-high), in_port (async IR line, low = mark),
//        address/read/write/writedata/readdata (Avalon-MM slave), irq (level).
module ir_nec_rx #(
  parameter int TICK_DIV    = 500,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_port,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

  typedef enum logic [2:0] {IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, CHECK} state_t;

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   line_q;
  logic [DW-1:0]          div_q;
  logic [10:0]            cnt_q;
  state_t                 state_q, state_nxt;
  logic [4:0]             bit_idx_q, bit_idx_nxt;
  logic [31:0]            shift_q, shift_nxt;
  logic [31:0]            data_q;
  logic [3:0]             status_q;
  logic [1:0]             control_q;
  logic [7:0]             errcnt_q;

  logic line, fall, rise, tick;
  logic err, set_repeat, frame_ok, frame_bad, bit_val;
  logic [3:0] status_w1c, status_set;

  assign line = sync_q[SYNC_STAGES-1];
  assign fall = line_q & ~line;
  assign rise = ~line_q & line;
  assign tick = (div_q == DW'(TICK_DIV - 1));

  function automatic logic in_rng(input logic [10:0] v, input logic [10:0] lo, input logic [10:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  always_comb begin
    state_nxt   = state_q;
    bit_idx_nxt = bit_idx_q;
    shift_nxt   = shift_q;
    err         = 1'b0;
    set_repeat  = 1'b0;
    frame_ok    = 1'b0;
    frame_bad   = 1'b0;
    bit_val     = 1'b0;
    if (!control_q[0]) begin
      // Disabling aborts silently: no error, no DATA update.
      state_nxt = IDLE;
    end else if (state_q != IDLE && state_q != CHECK && cnt_q >= 11'd1100) begin
      state_nxt = IDLE;
      err       = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (fall) state_nxt = LEAD_MARK;
        LEAD_MARK: if (rise) begin
          if (in_rng(cnt_q, 11'd800, 11'd1000)) state_nxt = LEAD_SPACE;
          else begin state_nxt = IDLE; err = 1'b1; end
        end
        LEAD_SPACE: if (fall) begin
          if (in_rng(cnt_q, 11'd400, 11'd500)) begin
            state_nxt   = BIT_MARK;
            bit_idx_nxt = 5'd0;
          end else if (in_rng(cnt_q, 11'd180, 11'd270)) begin
            state_nxt  = IDLE;
            set_repeat = 1'b1;
          end else begin
            state_nxt = IDLE;
            err       = 1'b1;
          end
        end
        BIT_MARK: if (rise) begin
          if (in_rng(cnt_q, 11'd40, 11'd70)) state_nxt = BIT_SPACE;
          else begin state_nxt = IDLE; err = 1'b1; end
        end
        BIT_SPACE: if (fall) begin
          if (in_rng(cnt_q, 11'd40, 11'd70) || in_rng(cnt_q, 11'd140, 11'd190)) begin
            bit_val            = in_rng(cnt_q, 11'd140, 11'd190);
            shift_nxt[bit_idx_q] = bit_val;
            if (bit_idx_q == 5'd31) state_nxt = CHECK;
            else begin
              state_nxt   = BIT_MARK;
              bit_idx_nxt = bit_idx_q + 5'd1;
            end
          end else begin
            state_nxt = IDLE;
            err       = 1'b1;
          end
        end
        CHECK: begin
          state_nxt = IDLE;
          if (shift_q[15:8] == ~shift_q[7:0] && shift_q[31:24] == ~shift_q[23:16]) frame_ok = 1'b1;
          else frame_bad = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Hardware set is OR-ed after the W1C mask so a same-cycle set survives.
  assign status_w1c = (write && address == 2'd1) ? writedata[3:0] : 4'd0;
  assign status_set = {frame_ok & status_q[0], frame_bad | err, set_repeat, frame_ok};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '1;
      line_q    <= 1'b1;
      div_q     <= '0;
      cnt_q     <= '0;
      state_q   <= IDLE;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      status_q  <= '0;
      control_q <= '0;
      errcnt_q  <= '0;
      readdata  <= '0;
      irq       <= 1'b0;
    end else begin
      sync_q    <= (sync_q << 1) | SYNC_STAGES'(in_port);
      line_q    <= line;
      div_q     <= tick ? '0 : div_q + DW'(1);
      if (fall || rise) cnt_q <= '0;
      else if (tick && cnt_q != 11'd2047) cnt_q <= cnt_q + 11'd1;
      state_q   <= state_nxt;
      bit_idx_q <= bit_idx_nxt;
      shift_q   <= shift_nxt;
      if (frame_ok) data_q <= shift_q;
      status_q  <= (status_q & ~status_w1c) | status_set;
      if (write && address == 2'd2) control_q <= writedata[1:0];
      if (write && address == 2'd3) errcnt_q <= '0;
      else if (err && errcnt_q != 8'd255) errcnt_q <= errcnt_q + 8'd1;
      if (read) begin
        case (address)
          2'd0:    readdata <= data_q;
          2'd1:    readdata <= {28'd0, status_q};
          2'd2:    readdata <= {30'd0, control_q};
          default: readdata <= {24'd0, errcnt_q};
        endcase
      end
      irq <= control_q[1] & (status_q[0] | status_q[1] | status_q[2]);
    end
  end

endmodule
